// File: rtl/vga_scan_addr_gen.sv
// Address sequencer sweeping 0..DEPTH-1 with a programmable window strobe.
// Optional advance prescaler enabled by defining SCAN_ADDR_PRESCALE_EN.
module vga_scan_addr_gen #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned WIN_LO_DEF = 701,
    parameter int unsigned WIN_HI_DEF = 1023,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              one_shot,
    input  logic [ADDR_W-1:0] step,
    input  logic [ADDR_W-1:0] win_lo,
    input  logic [ADDR_W-1:0] win_hi,
    output logic [ADDR_W-1:0] vga_add,
    output logic              addr_valid,
    output logic              vga_write_rom_value,
    output logic              wrap,
    output logic              done,
    output logic              busy
);

`ifdef SCAN_ADDR_PRESCALE_EN
    localparam int unsigned PreN = (PRESCALE > 1) ? PRESCALE : 1;
`else
    // Without the feature every clock is an advance, whatever PRESCALE says.
    localparam int unsigned PreN = (PRESCALE > 0) ? 1 : 1;
`endif
    localparam int unsigned PreW = (PreN > 1) ? $clog2(PreN) : 1;

    localparam logic [ADDR_W:0]   DepthX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LoDef  = ADDR_W'(WIN_LO_DEF);
    localparam logic [ADDR_W-1:0] HiDef  = ADDR_W'(WIN_HI_DEF);
    localparam logic [ADDR_W-1:0] OneW   = ADDR_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] step_q, lo_q, hi_q;
    logic              one_shot_q;
    logic [PreW-1:0]   pre_q;

    logic [ADDR_W:0]   sum;
    logic [ADDR_W-1:0] next_add;
    logic              at_end;
    logic              advance;

    function automatic logic in_window(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] lo,
                                       input logic [ADDR_W-1:0] hi);
        if (lo <= hi) return (a >= lo) && (a <= hi);
        else          return (a >= lo) || (a <= hi);
    endfunction

    always_comb begin
        sum      = {1'b0, vga_add} + {1'b0, step_q};
        at_end   = (sum >= DepthX);
        next_add = at_end ? ADDR_W'(sum - DepthX) : sum[ADDR_W-1:0];
        advance  = (pre_q == PreW'(PreN - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (stop || state_q != StRun || advance) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PreW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= StIdle;
            step_q              <= OneW;
            lo_q                <= LoDef;
            hi_q                <= HiDef;
            one_shot_q          <= 1'b0;
            vga_add             <= '0;
            addr_valid          <= 1'b0;
            vga_write_rom_value <= 1'b0;
            wrap                <= 1'b0;
            done                <= 1'b0;
            busy                <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            if (stop) begin
                // Abort: address holds, everything else drops.
                state_q             <= StIdle;
                addr_valid          <= 1'b0;
                vga_write_rom_value <= 1'b0;
                busy                <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            step_q              <= (step == '0) ? OneW : step;
                            lo_q                <= win_lo;
                            hi_q                <= win_hi;
                            one_shot_q          <= one_shot;
                            vga_add             <= '0;
                            addr_valid          <= 1'b1;
                            busy                <= 1'b1;
                            vga_write_rom_value <= in_window('0, win_lo, win_hi);
                            state_q             <= StRun;
                        end
                    end
                    StRun: begin
                        if (advance) begin
                            if (at_end && one_shot_q) begin
                                state_q             <= StDone;
                                addr_valid          <= 1'b0;
                                busy                <= 1'b0;
                                vga_write_rom_value <= 1'b0;
                                done                <= 1'b1;
                            end else begin
                                vga_add             <= next_add;
                                wrap                <= at_end;
                                vga_write_rom_value <= in_window(next_add, lo_q, hi_q);
                            end
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_addr_gen.sv
// Directed table-driven bench for vga_scan_addr_gen (default and DEPTH=1000 instances).
module tb_vga_scan_addr_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, start2, one_shot;
    logic [9:0] step, win_lo, win_hi;

    logic [9:0] vga_add, vga_add2;
    logic       addr_valid, win, wrap, done, busy;
    logic       addr_valid2, win2, wrap2, done2, busy2;

    int total = 0;
    int bad   = 0;

    vga_scan_addr_gen #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .one_shot(one_shot),
        .step(step), .win_lo(win_lo), .win_hi(win_hi), .vga_add(vga_add),
        .addr_valid(addr_valid), .vga_write_rom_value(win), .wrap(wrap), .done(done),
        .busy(busy)
    );

    vga_scan_addr_gen #(.ADDR_W(10), .DEPTH(1000)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(1'b0), .one_shot(one_shot),
        .step(step), .win_lo(win_lo), .win_hi(win_hi), .vga_add(vga_add2),
        .addr_valid(addr_valid2), .vga_write_rom_value(win2), .wrap(wrap2), .done(done2),
        .busy(busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int step; bit os; int lo; int hi; int n;
        int add; bit valid; bit win; bit wrap; bit done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n counts clocks from the start edge: n=1 is the first valid address 0.
    task automatic launch(input int st, input bit os, input int lo, input int hi);
        stop = 1'b1;
        tick();
        stop     = 1'b0;
        step     = 10'(st);
        one_shot = os;
        win_lo   = 10'(lo);
        win_hi   = 10'(hi);
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int errs;
        int wraps;
        int strobes;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0; one_shot = 1'b0;
        step = '0; win_lo = '0; win_hi = '0;
        #12;
        check("rst_add", int'(vga_add), 0);
        check("rst_valid", int'(addr_valid), 0);
        check("rst_win", int'(win), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wrap_done", int'({wrap, done}), 0);
        rst_n = 1'b1;
        #5;

        // One-shot sweep with DEPTH=1000, step 3.
        @(posedge clk); #1;
        step = 10'd3; one_shot = 1'b1; win_lo = 10'd701; win_hi = 10'd1023;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        errs  = (vga_add2 != 10'd0) ? 1 : 0;
        wraps = 0;
        for (int n = 2; n <= 334; n++) begin
            tick();
            if (int'(vga_add2) != 3 * (n - 1) || !addr_valid2) errs++;
            if (wrap2) wraps++;
        end
        check("os_seq_errs", errs, 0);
        check("os_last_add", int'(vga_add2), 999);
        check("os_last_win", int'(win2), 1);
        tick();
        if (wrap2) wraps++;
        check("os_done", int'(done2), 1);
        check("os_done_add", int'(vga_add2), 999);
        check("os_done_valid", int'(addr_valid2), 0);
        check("os_done_busy", int'(busy2), 0);
        tick();
        check("os_done_pulse_end", int'(done2), 0);
        check("os_no_wrap", wraps, 0);

        // Table: step, one_shot, lo, hi, n, add, valid, win, wrap, done
        vecs.push_back('{1, 0, 701, 1023, 1,    0,    1, 0, 0, 0});
        vecs.push_back('{1, 0, 701, 1023, 701,  700,  1, 0, 0, 0});
        vecs.push_back('{1, 0, 701, 1023, 702,  701,  1, 1, 0, 0});
        vecs.push_back('{1, 0, 701, 1023, 1024, 1023, 1, 1, 0, 0});
        vecs.push_back('{1, 0, 701, 1023, 1025, 0,    1, 0, 1, 0});
        vecs.push_back('{1, 0, 1000, 20,  1,    0,    1, 1, 0, 0});
        vecs.push_back('{1, 0, 1000, 20,  21,   20,   1, 1, 0, 0});
        vecs.push_back('{1, 0, 1000, 20,  22,   21,   1, 0, 0, 0});
        vecs.push_back('{1, 0, 1000, 20,  1000, 999,  1, 0, 0, 0});
        vecs.push_back('{1, 0, 1000, 20,  1001, 1000, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 0,    10,  6,    5,    1, 1, 0, 0});
        vecs.push_back('{100, 0, 200, 300, 4,   300,  1, 1, 0, 0});
        vecs.push_back('{100, 0, 200, 300, 11,  1000, 1, 0, 0, 0});
        vecs.push_back('{100, 0, 200, 300, 12,  76,   1, 0, 1, 0});
        vecs.push_back('{512, 1, 701, 1023, 2,  512,  1, 0, 0, 0});
        vecs.push_back('{512, 1, 701, 1023, 3,  512,  0, 0, 0, 1});

        foreach (vecs[i]) begin
            launch(vecs[i].step, vecs[i].os, vecs[i].lo, vecs[i].hi);
            repeat (vecs[i].n - 1) tick();
            check($sformatf("vec%0d_add", i), int'(vga_add), vecs[i].add);
            check($sformatf("vec%0d_valid", i), int'(addr_valid), int'(vecs[i].valid));
            check($sformatf("vec%0d_win", i), int'(win), int'(vecs[i].win));
            check($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].wrap));
            check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].done));
        end

        // Full continuous sweep: 323 strobe cycles, address follows n-1.
        launch(1, 0, 701, 1023);
        errs = 0; strobes = 0; wraps = 0;
        for (int n = 1; n <= 1024; n++) begin
            if (n > 1) tick();
            if (int'(vga_add) != n - 1) errs++;
            if (win) strobes++;
            if (wrap) wraps++;
        end
        tick();
        check("sweep_addr_errs", errs, 0);
        check("sweep_strobes", strobes, 323);
        check("sweep_no_early_wrap", wraps, 0);
        check("sweep_wrap", int'(wrap), 1);
        check("sweep_wrap_add", int'(vga_add), 0);
        tick();
        check("sweep_wrap_pulse_end", int'(wrap), 0);

        // Stop wins over start, address holds, restart from 0.
        launch(1, 0, 701, 1023);
        repeat (500) tick();
        check("stop_pre_add", int'(vga_add), 500);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        check("stop_add_hold", int'(vga_add), 500);
        check("stop_valid", int'(addr_valid), 0);
        check("stop_win", int'(win), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_no_done", int'(done), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_add", int'(vga_add), 0);
        check("restart_valid", int'(addr_valid), 1);
        tick();
        check("restart_add1", int'(vga_add), 1);

        // Start ignored while running.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_ignored", int'(vga_add), 2);

        // Asynchronous reset mid-sweep.
        launch(1, 0, 0, 10);
        repeat (800) tick();
        check("prerst_add", int'(vga_add), 800);
        rst_n = 1'b0;
        #1;
        check("arst_add", int'(vga_add), 0);
        check("arst_valid", int'(addr_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_win", int'(win), 0);
        #2;
        rst_n = 1'b1;
        win_lo = 10'd701; win_hi = 10'd1023; step = 10'd1; one_shot = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("postrst_add0", int'(vga_add), 0);
        repeat (700) tick();
        check("postrst_win700", int'(win), 0);
        tick();
        check("postrst_add701", int'(vga_add), 701);
        check("postrst_win701", int'(win), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
